// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller: size defaults and FSM encoding.
package fifo_pkg;

  localparam int unsigned MAIN_SIZE_DEF = 6;
  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned DEPTH         = 2 ** MAIN_SIZE_DEF;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Memory address pointer: synchronous clear, increment on enable, natural wrap at 2**W.
module fifo_ptr_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)     ptr_d = '0;
    else if (en) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_6x8.sv
// Pointer/flag controller for the 6x8 FIFO memory: FSM, occupancy count and status flags.
// Optional FIFO_ERR_CLR_EN adds err_clr, allowing ERROR to be left without a reset.
module fifo_ctrl_6x8
  import fifo_pkg::*;
#(
  parameter int unsigned MAIN_SIZE = MAIN_SIZE_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [MAIN_SIZE:0]   th_afull,
  input  logic [MAIN_SIZE:0]   th_aempty,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic                 read,
  output logic [MAIN_SIZE-1:0] wr_ptr,
  output logic [MAIN_SIZE-1:0] rd_ptr,
  output logic                 data_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [MAIN_SIZE:0]   count,
  output logic                 error,
  output logic [2:0]           state
`ifdef FIFO_ERR_CLR_EN
  ,
  input  logic                 err_clr
`endif
);

  localparam logic [MAIN_SIZE:0] FULL_LVL = {1'b1, {MAIN_SIZE{1'b0}}};

  state_e             state_q, state_d;
  logic [MAIN_SIZE:0] count_q, count_d;
  logic [MAIN_SIZE:0] th_afull_q, th_afull_d;
  logic [MAIN_SIZE:0] th_aempty_q, th_aempty_d;
  logic               error_q, error_d;
  logic               data_valid_q;
  logic               op_en, ovf, udf, ptr_clr, clr_req;

`ifdef FIFO_ERR_CLR_EN
  assign clr_req = err_clr;
`else
  assign clr_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      th_afull_q   <= '0;
      th_aempty_q  <= '0;
      error_q      <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      th_afull_q   <= th_afull_d;
      th_aempty_q  <= th_aempty_d;
      error_q      <= error_d;
      data_valid_q <= read;
    end
  end

  // Output/flag logic; almost_full is masked in RESET since the reset threshold of 0 would assert it.
  always_comb begin
    op_en        = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    fifo_full    = (count_q == FULL_LVL);
    fifo_empty   = (count_q == '0);
    almost_full  = (state_q != ST_RESET) && (count_q >= th_afull_q);
    almost_empty = (count_q <= th_aempty_q);
    write        = op_en & push & ~fifo_full;
    read         = op_en & pop & ~fifo_empty;
    ovf          = op_en & push & fifo_full;
    udf          = op_en & pop & fifo_empty;
  end

  always_comb begin
    count_d     = count_q;
    th_afull_d  = th_afull_q;
    th_aempty_d = th_aempty_q;
    error_d     = error_q;
    ptr_clr     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        th_afull_d  = th_afull;
        th_aempty_d = th_aempty;
        count_d     = '0;
        ptr_clr     = 1'b1;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (write && !read)      count_d = count_q + 1'b1;
        else if (read && !write) count_d = count_q - 1'b1;
        if (ovf || udf) error_d = 1'b1;
      end
      ST_ERROR: begin
        if (clr_req) begin
          error_d = 1'b0;
          count_d = '0;
          ptr_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Overflow/underflow takes priority over init so the sticky error always lands in ERROR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (ovf || udf)                                  state_d = ST_ERROR;
        else if (init)                                   state_d = ST_INIT;
        else if (state_q == ST_IDLE && write)            state_d = ST_ACTIVE;
        else if (state_q == ST_ACTIVE && count_d == '0)  state_d = ST_IDLE;
      end
      ST_ERROR: state_d = clr_req ? ST_INIT : ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  fifo_ptr_cnt #(.W(MAIN_SIZE)) u_wr_ptr (
    .clk (clk),
    .rst (reset),
    .clr (ptr_clr),
    .en  (write),
    .ptr (wr_ptr)
  );

  fifo_ptr_cnt #(.W(MAIN_SIZE)) u_rd_ptr (
    .clk (clk),
    .rst (reset),
    .clr (ptr_clr),
    .en  (read),
    .ptr (rd_ptr)
  );

  assign count      = count_q;
  assign error      = error_q;
  assign data_valid = data_valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fifo_ctrl_6x8.sv
// Directed testbench for fifo_ctrl_6x8 (build with +define+FIFO_ERR_CLR_EN to exercise err_clr).
module tb_fifo_ctrl_6x8;

  logic       clk;
  logic       reset;
  logic       init;
  logic [6:0] th_afull;
  logic [6:0] th_aempty;
  logic       push;
  logic       pop;
  logic       write;
  logic       read;
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic       data_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [6:0] count;
  logic       error;
  logic [2:0] state;
`ifdef FIFO_ERR_CLR_EN
  logic       err_clr;
`endif

  int nvec = 0;
  int nerr = 0;

  fifo_ctrl_6x8 #(.MAIN_SIZE(6), .DATA_SIZE(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .th_afull     (th_afull),
    .th_aempty    (th_aempty),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .data_valid   (data_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error),
    .state        (state)
`ifdef FIFO_ERR_CLR_EN
    ,
    .err_clr      (err_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    init  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d expected 0", state); end
    nvec++; if (count !== 7'd0) begin nerr++; $display("FAIL rst_count: got %0d expected 0", count); end
    nvec++; if ({wr_ptr, rd_ptr} !== 12'd0) begin nerr++; $display("FAIL rst_ptrs: got %0d/%0d expected 0/0", wr_ptr, rd_ptr); end
    nvec++; if ({fifo_empty, almost_empty} !== 2'b11) begin nerr++; $display("FAIL rst_empty_flags: got %b expected 11", {fifo_empty, almost_empty}); end
    nvec++; if ({fifo_full, almost_full, error, write, read, data_valid} !== 6'b0) begin
      nerr++; $display("FAIL rst_zero_outs: got %b expected 000000", {fifo_full, almost_full, error, write, read, data_valid});
    end
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    nvec++; if (state !== 3'd1) begin nerr++; $display("FAIL state_init: got %0d expected 1", state); end
    tick();
    nvec++; if (state !== 3'd2) begin nerr++; $display("FAIL state_idle: got %0d expected 2", state); end
    nvec++; if ({fifo_empty, almost_empty, count} !== {2'b11, 7'd0}) begin
      nerr++; $display("FAIL idle_flags: got empty=%b aempty=%b count=%0d expected 1 1 0", fifo_empty, almost_empty, count);
    end
  endtask

  task automatic test_push_pop();
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (write !== 1'b1) begin nerr++; $display("FAIL push_write[%0d]: got %b expected 1", i, write); end
      tick();
      nvec++; if (wr_ptr !== 6'(i + 1) || count !== 7'(i + 1)) begin
        nerr++; $display("FAIL push_ptr_cnt[%0d]: got ptr=%0d cnt=%0d expected %0d", i, wr_ptr, count, i + 1);
      end
      nvec++; if (almost_empty !== (i + 1 <= 4)) begin nerr++; $display("FAIL push_aempty[%0d]: got %b expected %b", i, almost_empty, (i + 1 <= 4)); end
    end
    push = 1'b0;
    nvec++; if (state !== 3'd3) begin nerr++; $display("FAIL state_active: got %0d expected 3", state); end
    pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (read !== 1'b1) begin nerr++; $display("FAIL pop_read[%0d]: got %b expected 1", i, read); end
      tick();
      nvec++; if (rd_ptr !== 6'(i + 1) || count !== 7'(4 - i)) begin
        nerr++; $display("FAIL pop_ptr_cnt[%0d]: got ptr=%0d cnt=%0d expected %0d %0d", i, rd_ptr, count, i + 1, 4 - i);
      end
      nvec++; if (data_valid !== 1'b1 || almost_empty !== 1'b1) begin
        nerr++; $display("FAIL pop_dv_aempty[%0d]: got dv=%b ae=%b expected 1 1", i, data_valid, almost_empty);
      end
    end
    pop = 1'b0;
    nvec++; if (state !== 3'd2) begin nerr++; $display("FAIL state_back_idle: got %0d expected 2", state); end
    tick();
    nvec++; if (data_valid !== 1'b0) begin nerr++; $display("FAIL dv_drop: got %b expected 0", data_valid); end
  endtask

  task automatic test_fill_overflow();
    restart();
    push = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      nvec++; if (count !== 7'(i + 1) || almost_full !== (i + 1 >= 60)) begin
        nerr++; $display("FAIL fill[%0d]: got cnt=%0d af=%b expected %0d %b", i, count, almost_full, i + 1, (i + 1 >= 60));
      end
    end
    nvec++; if (fifo_full !== 1'b1 || wr_ptr !== 6'd0) begin nerr++; $display("FAIL full_wrap: got full=%b ptr=%0d expected 1 0", fifo_full, wr_ptr); end
    nvec++; if (write !== 1'b0) begin nerr++; $display("FAIL ovf_write: got %b expected 0", write); end
    tick();
    nvec++; if (state !== 3'd4 || error !== 1'b1 || count !== 7'd64) begin
      nerr++; $display("FAIL ovf_err: got st=%0d err=%b cnt=%0d expected 4 1 64", state, error, count);
    end
    push = 1'b0;
    tick();
    nvec++; if (state !== 3'd4 || error !== 1'b1) begin nerr++; $display("FAIL ovf_hold: got st=%0d err=%b expected 4 1", state, error); end
  endtask

  task automatic test_full_push_pop();
    restart();
    push = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    pop = 1'b1;
    #1;
    nvec++; if ({read, write} !== 2'b10) begin nerr++; $display("FAIL full_pp_strobes: got rd/wr=%b expected 10", {read, write}); end
    tick();
    push = 1'b0;
    pop  = 1'b0;
    nvec++; if (state !== 3'd4 || count !== 7'd63 || rd_ptr !== 6'd1 || error !== 1'b1) begin
      nerr++; $display("FAIL full_pp_result: got st=%0d cnt=%0d rp=%0d err=%b expected 4 63 1 1", state, count, rd_ptr, error);
    end
  endtask

  task automatic test_empty_push_pop();
    restart();
    push = 1'b1;
    pop  = 1'b1;
    #1;
    nvec++; if ({read, write} !== 2'b01) begin nerr++; $display("FAIL empty_pp_strobes: got rd/wr=%b expected 01", {read, write}); end
    tick();
    nvec++; if (state !== 3'd4 || count !== 7'd1 || wr_ptr !== 6'd1 || error !== 1'b1) begin
      nerr++; $display("FAIL empty_pp_result: got st=%0d cnt=%0d wp=%0d err=%b expected 4 1 1 1", state, count, wr_ptr, error);
    end
    tick();
    nvec++; if (count !== 7'd1 || {write, read} !== 2'b00) begin
      nerr++; $display("FAIL err_frozen: got cnt=%0d wr/rd=%b expected 1 00", count, {write, read});
    end
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_err_clr();
`ifdef FIFO_ERR_CLR_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    nvec++; if (state !== 3'd1 || error !== 1'b0 || count !== 7'd0) begin
      nerr++; $display("FAIL err_clr: got st=%0d err=%b cnt=%0d expected 1 0 0", state, error, count);
    end
    tick();
    nvec++; if (state !== 3'd2) begin nerr++; $display("FAIL err_clr_idle: got %0d expected 2", state); end
`else
    tick();
    tick();
    nvec++; if (state !== 3'd4 || error !== 1'b1 || count !== 7'd1) begin
      nerr++; $display("FAIL err_sticky: got st=%0d err=%b cnt=%0d expected 4 1 1", state, error, count);
    end
`endif
  endtask

  task automatic test_async_reset();
    restart();
    push = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    nvec++; if (count !== 7'd10) begin nerr++; $display("FAIL pre_reset_cnt: got %0d expected 10", count); end
    #2 reset = 1'b1;
    #1;
    nvec++; if (count !== 7'd0 || wr_ptr !== 6'd0 || state !== 3'd0) begin
      nerr++; $display("FAIL async_rst: got cnt=%0d wp=%0d st=%0d expected 0 0 0", count, wr_ptr, state);
    end
    nvec++; if ({fifo_empty, almost_empty, write, almost_full} !== 4'b1100) begin
      nerr++; $display("FAIL async_rst_flags: got %b expected 1100", {fifo_empty, almost_empty, write, almost_full});
    end
    push = 1'b0;
    #3 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    init      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    th_afull  = 7'd60;
    th_aempty = 7'd4;
`ifdef FIFO_ERR_CLR_EN
    err_clr   = 1'b0;
`endif
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_err_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
